// File: rtl/al_accel_pkg.sv
// Shared types and constants for the 3x3 convolution accelerator blocks.
package al_accel_pkg;

  localparam int unsigned AL_DW     = 8;
  localparam int unsigned AL_KROWS  = 3;
  localparam int unsigned AL_KCOLS  = 3;
  localparam int unsigned AL_KCNT_W = 8;

  typedef enum logic [1:0] {
    WL_IDLE  = 2'd0,
    WL_FILL  = 2'd1,
    WL_WRITE = 2'd2,
    WL_DONE  = 2'd3
  } wl_state_e;

endpackage

// File: rtl/al_accel_wload.sv
// Weight loader: packs a byte stream into 3-byte kernel rows and strobes them to the weight bank.
// Optional build macro AL_ACCEL_WLOAD_CKSUM_EN adds a mod-256 byte checksum compare.
module al_accel_wload
  import al_accel_pkg::*;
#(
  parameter int unsigned DW     = AL_DW,
  parameter int unsigned KROWS  = AL_KROWS,
  parameter int unsigned KCNT_W = AL_KCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wl_start,
  input  logic              wl_abort,
  input  logic [KCNT_W-1:0] wl_num_kern,
  input  logic [DW-1:0]     s_data,
  input  logic              s_valid,
`ifdef AL_ACCEL_WLOAD_CKSUM_EN
  input  logic [7:0]        wl_cksum_exp,
  output logic              wl_cksum_err,
`endif
  output logic              s_ready,
  output logic [DW-1:0]     wl_do_0,
  output logic [DW-1:0]     wl_do_1,
  output logic [DW-1:0]     wl_do_2,
  output logic [1:0]        wl_sel,
  output logic              wl_row_we,
  output logic [KCNT_W-1:0] wl_kern_idx,
  output logic              wl_busy,
  output logic              wl_done
);

  localparam logic [1:0] ROW_LAST = 2'(KROWS - 1);
  localparam logic [1:0] COL_LAST = 2'(AL_KCOLS - 1);

  wl_state_e         state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [KCNT_W-1:0] kidx_q, kidx_d;
  logic [KCNT_W-1:0] num_q, num_d;
  logic [DW-1:0]     do0_q, do0_d, do1_q, do1_d, do2_q, do2_d;
  logic              s_ready_q, s_ready_d;
  logic              row_we_q, row_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_acc;
  logic              hs;

  assign start_acc = (state_q == WL_IDLE) && wl_start && !wl_abort;
  assign hs        = (state_q == WL_FILL) && s_valid && !wl_abort;

  // Next-state, counters, row pack registers and registered Moore outputs
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    kidx_d  = kidx_q;
    num_d   = num_q;
    do0_d   = do0_q;
    do1_d   = do1_q;
    do2_d   = do2_q;

    if (wl_abort) begin
      state_d = WL_IDLE;
      col_d   = 2'd0;
    end else begin
      unique case (state_q)
        WL_IDLE: begin
          if (wl_start) begin
            num_d   = wl_num_kern;
            col_d   = 2'd0;
            row_d   = 2'd0;
            kidx_d  = '0;
            state_d = (wl_num_kern != '0) ? WL_FILL : WL_DONE;
          end
        end
        WL_FILL: begin
          if (s_valid) begin
            case (col_q)
              2'd0:    do0_d = s_data;
              2'd1:    do1_d = s_data;
              default: do2_d = s_data;
            endcase
            if (col_q == COL_LAST) begin
              col_d   = 2'd0;
              state_d = WL_WRITE;
            end else begin
              col_d = col_q + 2'd1;
            end
          end
        end
        WL_WRITE: begin
          if (row_q != ROW_LAST) begin
            row_d   = row_q + 2'd1;
            state_d = WL_FILL;
          end else if (kidx_q < (num_q - KCNT_W'(1))) begin
            kidx_d  = kidx_q + KCNT_W'(1);
            row_d   = 2'd0;
            state_d = WL_FILL;
          end else begin
            state_d = WL_DONE;
          end
        end
        WL_DONE: state_d = WL_IDLE;
        default: state_d = WL_IDLE;
      endcase
    end

    s_ready_d = (state_d == WL_FILL);
    row_we_d  = (state_d == WL_WRITE);
    busy_d    = (state_d != WL_IDLE);
    done_d    = (state_d == WL_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WL_IDLE;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      kidx_q    <= '0;
      num_q     <= '0;
      do0_q     <= '0;
      do1_q     <= '0;
      do2_q     <= '0;
      s_ready_q <= 1'b0;
      row_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      kidx_q    <= kidx_d;
      num_q     <= num_d;
      do0_q     <= do0_d;
      do1_q     <= do1_d;
      do2_q     <= do2_d;
      s_ready_q <= s_ready_d;
      row_we_q  <= row_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef AL_ACCEL_WLOAD_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;

  // Running sum of accepted bytes; compared once when the load completes
  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (start_acc) begin
      sum_d = 8'd0;
      err_d = 1'b0;
    end else if (hs) begin
      sum_d = sum_q + 8'(s_data);
    end
    if (wl_abort) begin
      err_d = 1'b0;
    end else if ((state_d == WL_DONE) && (state_q != WL_DONE)) begin
      err_d = (sum_d != wl_cksum_exp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign wl_cksum_err = err_q;
`endif

  assign s_ready     = s_ready_q;
  assign wl_row_we   = row_we_q;
  assign wl_busy     = busy_q;
  assign wl_done     = done_q;
  assign wl_sel      = row_q;
  assign wl_kern_idx = kidx_q;
  assign wl_do_0     = do0_q;
  assign wl_do_1     = do1_q;
  assign wl_do_2     = do2_q;

endmodule
